// File: rtl/spram_arb_pkg.sv
// Shared types and helpers for the single-port RAM arbiter.
package spram_arb_pkg;

  typedef enum logic [0:0] {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Index width sized for the largest supported requester count.
  localparam int unsigned MAX_NREQ = 8;
  localparam int unsigned IDX_W    = $clog2(MAX_NREQ);

  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx,
                                               input int unsigned      n);
    logic [IDX_W-1:0] nxt;
    if (32'(idx) + 32'd1 >= n) begin
      nxt = '0;
    end else begin
      nxt = idx + IDX_W'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/spram.sv
// Synchronous single-port RAM, read latency 1; output holds during writes.
module spram #(
  parameter int DEPTH      = 256,
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Storage array and registered read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= '0;
    end else if (we) begin
      r_mem[addr] <= din;
    end else begin
      dout <= r_mem[addr];
    end
  end

endmodule

// File: rtl/spram_arbiter_rr.sv
// Combinational round-robin pick: first set request at or above i_ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ  = 2,
  parameter int PTR_W = 1
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [NREQ-1:0]  o_gnt,
  output logic [PTR_W-1:0] o_idx
);

  logic             w_found;
  logic             w_hit;
  logic [PTR_W-1:0] w_k;

  // Scan offsets from the pointer; the first hit wins and masks the rest.
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_hit   = 1'b0;
    w_k     = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      w_k        = PTR_W'((32'(i_ptr) + off) % NREQ);
      w_hit      = i_req[w_k] & ~w_found;
      o_gnt[w_k] = o_gnt[w_k] | w_hit;
      o_idx      = w_hit ? w_k : o_idx;
      w_found    = w_found | w_hit;
    end
  end

endmodule

// File: rtl/spram_arbiter.sv
// Round-robin arbiter with lock/timeout sharing one single-port RAM among NREQ requesters.
module spram_arbiter
  import spram_arb_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int DEPTH    = 256,
  parameter int WIDTH    = 8,
  parameter int LOCK_MAX = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NREQ-1:0]              req_valid,
  output logic [NREQ-1:0]              req_ready,
  input  logic [NREQ-1:0]              req_we,
  input  logic [NREQ-1:0]              req_lock,
  input  logic [NREQ*$clog2(DEPTH)-1:0] req_addr,
  input  logic [NREQ*WIDTH-1:0]        req_wdata,
  output logic [NREQ-1:0]              rsp_valid,
  output logic [WIDTH-1:0]             rsp_rdata,
  output logic                         ram_we,
  output logic [$clog2(DEPTH)-1:0]     ram_addr,
  output logic [WIDTH-1:0]             ram_din,
  input  logic [WIDTH-1:0]             ram_dout
);

  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam int PTR_W      = $clog2(NREQ);
  localparam int CNT_W      = $clog2(LOCK_MAX);

  arb_state_t       r_state;
  logic [PTR_W-1:0] r_rr_ptr;
  logic [PTR_W-1:0] r_owner;
  logic [CNT_W-1:0] r_lock_cnt;
  logic [NREQ-1:0]  r_rsp_valid;

  logic [NREQ-1:0]  w_arb_gnt;
  logic [PTR_W-1:0] w_arb_idx;
  logic [NREQ-1:0]  w_gnt;
  logic [PTR_W-1:0] w_idx;
  logic             w_accept;
  logic             w_lock_end;
  logic [PTR_W-1:0] w_gnt_next;
  logic [PTR_W-1:0] w_owner_next;

  rr_arbiter #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_rr (
    .i_req (req_valid),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_arb_gnt),
    .o_idx (w_arb_idx)
  );

  // Grant source: round-robin search in ARB, owner only while LOCKED.
  always_comb begin
    w_gnt = '0;
    w_idx = '0;
    if (r_state == LOCKED) begin
      w_gnt[r_owner] = req_valid[r_owner];
      w_idx          = r_owner;
    end else begin
      w_gnt = w_arb_gnt;
      w_idx = w_arb_idx;
    end
  end

  assign w_accept     = |w_gnt;
  assign w_lock_end   = (r_lock_cnt == CNT_W'(LOCK_MAX - 1));
  assign w_gnt_next   = PTR_W'(rr_next(IDX_W'(w_idx), NREQ));
  assign w_owner_next = PTR_W'(rr_next(IDX_W'(r_owner), NREQ));

  // RAM mux; an idle cycle becomes a read of address 0 whose data is ignored.
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    if (w_accept) begin
      ram_we   = req_we[w_idx];
      ram_addr = req_addr[32'(w_idx)*ADDR_WIDTH +: ADDR_WIDTH];
      ram_din  = req_wdata[32'(w_idx)*WIDTH +: WIDTH];
    end else begin
      ram_we   = 1'b0;
    end
  end

  // Ownership FSM, round-robin pointer and lock timeout counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ARB;
      r_rr_ptr   <= '0;
      r_owner    <= '0;
      r_lock_cnt <= '0;
    end else begin
      case (r_state)
        ARB: begin
          if (w_accept) begin
            r_rr_ptr <= w_gnt_next;
            if (req_lock[w_idx]) begin
              r_state    <= LOCKED;
              r_owner    <= w_idx;
              r_lock_cnt <= '0;
            end
          end
        end
        LOCKED: begin
          // A beat accepted in the forced-release cycle still completes normally.
          if ((w_accept && !req_lock[r_owner]) || w_lock_end) begin
            r_state    <= ARB;
            r_rr_ptr   <= w_owner_next;
            r_lock_cnt <= '0;
          end else begin
            r_lock_cnt <= r_lock_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= ARB;
        end
      endcase
    end
  end

  // Read response tag, one cycle after acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= '0;
    end else if (w_accept && !req_we[w_idx]) begin
      r_rsp_valid <= w_gnt;
    end else begin
      r_rsp_valid <= '0;
    end
  end

  assign req_ready = w_gnt;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = ram_dout;

endmodule

// File: tb/tb_spram_arbiter.sv
// Scoreboard bench for spram_arbiter driving a behavioural spram.
module tb_spram_arbiter;

  localparam int NREQ     = 2;
  localparam int AW       = 8;
  localparam int W        = 8;
  localparam int LOCK_MAX = 16;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid, req_ready, req_we, req_lock, rsp_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*W-1:0] req_wdata;
  logic [W-1:0]      rsp_rdata, ram_din, ram_dout;
  logic [AW-1:0]     ram_addr;
  logic              ram_we;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] mem_m [256];
  logic [9:0]   exp_q [$];
  logic [9:0]   push_e;
  logic [9:0]   pop_e;

  spram_arbiter #(
    .NREQ(NREQ), .DEPTH(256), .WIDTH(W), .LOCK_MAX(LOCK_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_lock(req_lock), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  spram #(.DEPTH(256), .WIDTH(W)) u_ram (
    .clk(clk), .rst(1'b0), .we(ram_we), .addr(ram_addr), .din(ram_din), .dout(ram_dout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Push the expected response for each cycle's accepted beat.
  always @(negedge clk) begin
    push_e = '0;
    if (rst_n) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          if (req_we[i]) mem_m[req_addr[i*AW +: AW]] = req_wdata[i*W +: W];
          else begin
            push_e[8+i]  = 1'b1;
            push_e[7:0]  = mem_m[req_addr[i*AW +: AW]];
          end
        end
      end
    end
    exp_q.push_back(push_e);
  end

  // Pop and compare after each edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) pop_e = exp_q.pop_front();
    else pop_e = '0;
    total++;
    if (rsp_valid !== pop_e[9:8]) begin
      bad++;
      $display("FAIL sb_rsp_valid t=%0t got=%b want=%b", $time, rsp_valid, pop_e[9:8]);
    end
    if (pop_e[9:8] != 2'b00) begin
      total++;
      if (rsp_rdata !== pop_e[7:0]) begin
        bad++;
        $display("FAIL sb_rsp_rdata t=%0t got=%h want=%h", $time, rsp_rdata, pop_e[7:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_all();
    req_valid = '0; req_we = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
  endtask

  task automatic set_req(input int i, input logic v, input logic we, input logic lk,
                         input logic [AW-1:0] a, input logic [W-1:0] d);
    req_valid[i] = v; req_we[i] = we; req_lock[i] = lk;
    req_addr[i*AW +: AW] = a; req_wdata[i*W +: W] = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_all();
    repeat (2) @(posedge clk);
    #3;
    total++;
    if (req_ready !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b want=00", req_ready); end
    total++;
    if (rsp_valid !== 2'b00) begin bad++; $display("FAIL reset_rsp got=%b want=00", rsp_valid); end
    total++;
    if (ram_we !== 1'b0 || ram_addr !== 8'h00 || ram_din !== 8'h00) begin
      bad++; $display("FAIL reset_ram_mux got we=%b addr=%h din=%h want 0/00/00", ram_we, ram_addr, ram_din);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    set_req(0, 1'b1, 1'b1, 1'b0, 8'd3, 8'hA5);
    #1;
    total++;
    if (req_ready !== 2'b01 || ram_we !== 1'b1 || ram_addr !== 8'd3 || ram_din !== 8'hA5) begin
      bad++; $display("FAIL wr_grant got rdy=%b we=%b addr=%h din=%h want 01/1/03/a5", req_ready, ram_we, ram_addr, ram_din);
    end
    tick();
    set_req(0, 1'b1, 1'b0, 1'b0, 8'd3, 8'h00);
    #1;
    total++;
    if (req_ready !== 2'b01 || ram_we !== 1'b0) begin
      bad++; $display("FAIL rd_grant got rdy=%b we=%b want 01/0", req_ready, ram_we);
    end
    @(posedge clk);
    #1;
    total++;
    if (rsp_valid !== 2'b01 || rsp_rdata !== 8'hA5) begin
      bad++; $display("FAIL rd_data got v=%b d=%h want 01/a5", rsp_valid, rsp_rdata);
    end
    #1;
    idle_all();
    tick();
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_r;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    set_req(0, 1'b1, 1'b0, 1'b0, 8'd3, 8'h00);
    set_req(1, 1'b1, 1'b0, 1'b0, 8'd3, 8'h00);
    for (int c = 0; c < 6; c++) begin
      exp_r = (c % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      total++;
      if (req_ready !== exp_r) begin
        bad++; $display("FAIL rr_grant cycle=%0d got=%b want=%b", c, req_ready, exp_r);
      end
      tick();
    end
    idle_all();
    tick();
  endtask

  task automatic test_rmw_lock();
    set_req(0, 1'b1, 1'b1, 1'b0, 8'd7, 8'h3C);
    #1;
    total++;
    if (req_ready !== 2'b01) begin bad++; $display("FAIL rmw_prewrite got=%b want=01", req_ready); end
    tick();
    set_req(0, 1'b1, 1'b0, 1'b0, 8'd3, 8'h00);
    set_req(1, 1'b1, 1'b0, 1'b1, 8'd7, 8'h00);
    #1;
    total++;
    if (req_ready !== 2'b10) begin bad++; $display("FAIL rmw_lock_read got=%b want=10", req_ready); end
    tick();
    set_req(1, 1'b0, 1'b0, 1'b0, 8'd0, 8'h00);
    #1;
    total++;
    if (req_ready !== 2'b00) begin bad++; $display("FAIL rmw_idle_owner got=%b want=00", req_ready); end
    tick();
    set_req(1, 1'b1, 1'b1, 1'b0, 8'd7, 8'h3D);
    #1;
    total++;
    if (req_ready !== 2'b10) begin bad++; $display("FAIL rmw_write got=%b want=10", req_ready); end
    tick();
    set_req(1, 1'b0, 1'b0, 1'b0, 8'd0, 8'h00);
    #1;
    total++;
    if (req_ready !== 2'b01) begin bad++; $display("FAIL rmw_release got=%b want=01", req_ready); end
    tick();
    set_req(0, 1'b1, 1'b0, 1'b0, 8'd7, 8'h00);
    #1;
    total++;
    if (req_ready !== 2'b01) begin bad++; $display("FAIL rmw_readback got=%b want=01", req_ready); end
    tick();
    idle_all();
    tick();
  endtask

  task automatic test_lock_timeout();
    set_req(0, 1'b1, 1'b0, 1'b1, 8'd3, 8'h00);
    #1;
    total++;
    if (req_ready !== 2'b01) begin bad++; $display("FAIL to_lock got=%b want=01", req_ready); end
    tick();
    set_req(0, 1'b0, 1'b0, 1'b0, 8'd0, 8'h00);
    set_req(1, 1'b1, 1'b0, 1'b0, 8'd3, 8'h00);
    for (int c = 0; c < LOCK_MAX; c++) begin
      #1;
      total++;
      if (req_ready !== 2'b00) begin bad++; $display("FAIL to_held cycle=%0d got=%b want=00", c, req_ready); end
      tick();
    end
    #1;
    total++;
    if (req_ready !== 2'b10) begin bad++; $display("FAIL to_release got=%b want=10", req_ready); end
    tick();
    idle_all();
    tick();
  endtask

  task automatic test_reset_mid();
    set_req(0, 1'b1, 1'b0, 1'b0, 8'd3, 8'h00);
    #1;
    total++;
    if (req_ready !== 2'b01) begin bad++; $display("FAIL rm_read got=%b want=01", req_ready); end
    @(posedge clk);
    #1;
    total++;
    if (rsp_valid !== 2'b01) begin bad++; $display("FAIL rm_rsp_before got=%b want=01", rsp_valid); end
    #1;
    idle_all();
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (rsp_valid !== 2'b00) begin bad++; $display("FAIL rm_rsp_cleared got=%b want=00", rsp_valid); end
    tick();
    rst_n = 1'b1;
    set_req(0, 1'b1, 1'b0, 1'b0, 8'd7, 8'h00);
    set_req(1, 1'b1, 1'b0, 1'b0, 8'd7, 8'h00);
    #1;
    total++;
    if (req_ready !== 2'b01) begin bad++; $display("FAIL rm_ptr0 got=%b want=01", req_ready); end
    tick();
    #1;
    total++;
    if (req_ready !== 2'b10) begin bad++; $display("FAIL rm_next got=%b want=10", req_ready); end
    tick();
    idle_all();
    tick();
    tick();
  endtask

  initial begin
    idle_all();
    rst_n = 1'b0;
    test_reset();
    test_write_read();
    test_round_robin();
    test_rmw_lock();
    test_lock_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
